// File: rtl/bist_pattern_ctrl_if.sv
// bist_pattern_ctrl_if: start/response/mux-control bundle between test driver and BIST sequencer
interface bist_pattern_ctrl_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] resp;
  logic             sel;
  logic [WIDTH-1:0] pattern;
  logic             busy;
  logic             done;
  logic             pass;
  modport master (output start, resp, input sel, pattern, busy, done, pass);
  modport slave (input start, resp, output sel, pattern, busy, done, pass);
endinterface

// File: rtl/bist_pattern_ctrl.sv
// bist_pattern_ctrl: LFSR pattern source, MISR response compactor and pass/fail sequencer for one self-test per start
module bist_pattern_ctrl #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] SEED         = 4'b0001,
  parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
  parameter int               NUM_PATTERNS = 15,
  parameter logic [WIDTH-1:0] GOLDEN       = 4'b0000
) (
  input logic               clk,
  input logic               rst,
  bist_pattern_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, SIG, DONE} state_t;
  localparam logic [7:0] LAST = 8'(NUM_PATTERNS - 1);
  state_t           state;
  logic [7:0]       count;
  logic [WIDTH-1:0] misr;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] misr_next;
  // next LFSR pattern and next signature with the current response folded in
  always_comb begin
    lfsr_next = {bus.pattern[WIDTH-2:0], ^(bus.pattern & TAPS)};
    misr_next = {misr[WIDTH-2:0], ^(misr & TAPS)} ^ bus.resp;
  end
  // sequencer: every output is registered and updated on the state transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      misr        <= '0;
      bus.sel     <= 1'b0;
      bus.pattern <= SEED;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state       <= RUN;
          count       <= '0;
          misr        <= '0;
          bus.sel     <= 1'b1;
          bus.pattern <= SEED;
          bus.busy    <= 1'b1;
          bus.done    <= 1'b0;
          bus.pass    <= 1'b0;
        end
        RUN: begin
          misr        <= misr_next;
          count       <= count + 8'd1;
          state       <= (count == LAST) ? SIG : RUN;
          bus.sel     <= count != LAST;
          bus.pattern <= (count == LAST) ? SEED : lfsr_next;
        end
        SIG: begin
          state    <= DONE;
          bus.pass <= misr == GOLDEN;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// tb_bist_pattern_ctrl: scoreboard bench for the BIST sequencer, default and single-pattern configurations
module tb_bist_pattern_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bist_pattern_ctrl_if #(.WIDTH(4)) bus ();
  bist_pattern_ctrl_if #(.WIDTH(4)) bus1 ();
  bist_pattern_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  bist_pattern_ctrl #(.NUM_PATTERNS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  int checks = 0;
  int failures = 0;
  logic [3:0] exp_pat[$];
  logic       exp_res[$];
  logic [3:0] pats [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic done_q = 1'b0;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: pops an expected pattern for every cycle the mux is in test mode and an expected result at every done rise
  always @(negedge clk) begin
    if (bus.sel === 1'b1) begin
      if (exp_pat.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pattern actual=%h required=none at %0t", bus.pattern, $time);
      end else chk("pattern", 8'(bus.pattern), 8'(exp_pat.pop_front()));
    end
    if (bus.done === 1'b1 && !done_q) begin
      if (exp_res.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%b required=none at %0t", bus.pass, $time);
      end else chk("pass_result", 8'(bus.pass), 8'(exp_res.pop_front()));
    end
    done_q = bus.done;
  end
  task automatic run(input int hot, input bit hold, input bit exp_pass);
    @(negedge clk);
    bus.start = 1'b1;
    foreach (pats[i]) exp_pat.push_back(pats[i]);
    exp_res.push_back(exp_pass);
    for (int e = 0; e <= 16; e++) begin
      @(posedge clk);
      #1;
      bus.start = hold && e < 15;
      bus.resp = (e == hot) ? 4'd1 : 4'd0;
      chk("run_sel", 8'(bus.sel), 8'(e < 15));
      chk("run_busy", 8'(bus.busy), 8'(e < 16));
      chk("run_done", 8'(bus.done), 8'(e == 16));
      if (e == 0) chk("run_pass_clear", 8'(bus.pass), 8'd0);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("done_hold", 8'(bus.done), 8'd1);
      chk("pass_hold", 8'(bus.pass), 8'(exp_pass));
    end
  endtask
  task automatic abort_run();
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) exp_pat.push_back(pats[i]);
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.resp = 4'd0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_sel", 8'(bus.sel), 8'd0);
    chk("abort_pattern", 8'(bus.pattern), 8'h1);
    chk("abort_busy", 8'(bus.busy), 8'd0);
    chk("abort_done", 8'(bus.done), 8'd0);
    rst = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.resp = 4'd0;
    bus1.start = 1'b0;
    bus1.resp = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("idle_sel", 8'(bus.sel), 8'd0);
      chk("idle_pattern", 8'(bus.pattern), 8'h1);
      chk("idle_busy", 8'(bus.busy), 8'd0);
      chk("idle_done", 8'(bus.done), 8'd0);
      chk("idle_pass", 8'(bus.pass), 8'd0);
    end
    run(-1, 1'b0, 1'b1);
    run(-1, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0);
    abort_run();
    run(-1, 1'b0, 1'b1);
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    chk("np1_sel", 8'(bus1.sel), 8'd1);
    chk("np1_pattern", 8'(bus1.pattern), 8'h1);
    chk("np1_busy", 8'(bus1.busy), 8'd1);
    @(posedge clk);
    #1;
    chk("np1_sig_sel", 8'(bus1.sel), 8'd0);
    chk("np1_sig_busy", 8'(bus1.busy), 8'd1);
    chk("np1_sig_done", 8'(bus1.done), 8'd0);
    @(posedge clk);
    #1;
    chk("np1_done", 8'(bus1.done), 8'd1);
    chk("np1_busy_low", 8'(bus1.busy), 8'd0);
    chk("np1_pass", 8'(bus1.pass), 8'd1);
    @(negedge clk);
    chk("pat_queue_empty", 8'(exp_pat.size()), 8'd0);
    chk("res_queue_empty", 8'(exp_res.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
